// File: rtl/multicycle_ripple_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per clock, LSB chunk first.
// Define MULTICYCLE_ADDER_OVF_EN to add the signed-overflow output ovf.
module multicycle_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             c_out
`ifdef MULTICYCLE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("multicycle_ripple_adder: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
`ifdef MULTICYCLE_ADDER_OVF_EN
    logic              ovf_q, ovf_d;
    logic              c_msb;
`endif

    int                idx;
    logic [CHUNK-1:0]  a_ch, b_ch, sum_ch;
    logic              c_ch;
    logic              last;

    assign idx  = int'(k_q) * CHUNK;
    assign last = (k_q == KW'(NCHUNK - 1));

    // CHUNK-wide ripple chain fed by the carry registered from the previous chunk
    always_comb begin
        logic c;
        a_ch   = a_q[idx +: CHUNK];
        b_ch   = b_q[idx +: CHUNK];
        sum_ch = '0;
        c      = carry_q;
`ifdef MULTICYCLE_ADDER_OVF_EN
        c_msb  = 1'b0;
`endif
        for (int i = 0; i < CHUNK; i++) begin
            sum_ch[i] = a_ch[i] ^ b_ch[i] ^ c;
`ifdef MULTICYCLE_ADDER_OVF_EN
            c_msb = c;
`endif
            c = (a_ch[i] & b_ch[i]) | (c & (a_ch[i] ^ b_ch[i]));
        end
        c_ch = c;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
`ifdef MULTICYCLE_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new start directly so back-to-back ops skip IDLE
                if (start) begin
                    a_d     = A;
                    b_d     = B ^ {WIDTH{sub}};
                    carry_d = sub | c_in;
                    k_d     = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_d[idx +: CHUNK] = sum_ch;
                carry_d           = c_ch;
                k_d               = k_q + KW'(1);
                if (last) begin
                    cout_d  = c_ch;
`ifdef MULTICYCLE_ADDER_OVF_EN
                    ovf_d   = c_msb ^ c_ch;
`endif
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef MULTICYCLE_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign S     = s_q;
    assign c_out = cout_q;
`ifdef MULTICYCLE_ADDER_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule
